// File: rtl/exec_writeback.sv
// ============================================================================
//  Module   : exec_writeback
//  Purpose  : Multi-cycle execute stage with a single registered write-back
//             beat into a 16x16 register file.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exec_writeback #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int MUL_ITER = 16
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  D,
   output logic [ADDR_W-1:0] Rd,
   output logic              WE,
   output logic              Z,
   output logic              C
);

   localparam int CNT_W = $clog2(MUL_ITER);
   localparam int SH_W  = $clog2(WIDTH);

   localparam logic [2:0] c_OP_ADD   = 3'b000;
   localparam logic [2:0] c_OP_SUB   = 3'b001;
   localparam logic [2:0] c_OP_AND   = 3'b010;
   localparam logic [2:0] c_OP_OR    = 3'b011;
   localparam logic [2:0] c_OP_XOR   = 3'b100;
   localparam logic [2:0] c_OP_SHL   = 3'b101;
   localparam logic [2:0] c_OP_MUL   = 3'b110;
   localparam logic [2:0] c_OP_PASSB = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    a_q, a_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [2:0]          op_q, op_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  prod_q, prod_d;
   logic [WIDTH-1:0]    d_q, d_d;
   logic [ADDR_W-1:0]   rdo_q, rdo_d;
   logic                z_q, z_d;
   logic                c_q, c_d;

   logic [WIDTH-1:0]    w_alu_res;
   logic                w_alu_c;
   logic [WIDTH:0]      w_wide;
   logic [WIDTH:0]      w_mul_sum;
   logic [2*WIDTH-1:0]  w_mul_next;

   // Single-cycle ALU on the latched operands.
   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_wide    = '0;
      case (op_q)
         c_OP_ADD: begin
            w_wide    = {1'b0, a_q} + {1'b0, b_q};
            w_alu_res = w_wide[WIDTH-1:0];
            w_alu_c   = w_wide[WIDTH];
         end
         c_OP_SUB: begin
            w_wide    = {1'b0, a_q} - {1'b0, b_q};
            w_alu_res = w_wide[WIDTH-1:0];
            w_alu_c   = w_wide[WIDTH];
         end
         c_OP_AND:   w_alu_res = a_q & b_q;
         c_OP_OR:    w_alu_res = a_q | b_q;
         c_OP_XOR:   w_alu_res = a_q ^ b_q;
         c_OP_SHL: begin
            // The bit landing in position WIDTH is the last one shifted out.
            w_wide    = {1'b0, a_q} << b_q[SH_W-1:0];
            w_alu_res = w_wide[WIDTH-1:0];
            w_alu_c   = w_wide[WIDTH];
         end
         c_OP_PASSB: w_alu_res = b_q;
         default: begin
            w_alu_res = '0;
            w_alu_c   = 1'b0;
         end
      endcase
   end

   // Shift-add step: product high half accumulates A, whole register shifts right.
   always_comb begin
      w_mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      w_mul_next = {w_mul_sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      d_d     = d_q;
      rdo_d   = rdo_q;
      z_d     = z_q;
      c_d     = c_q;

      case (state_q)
         S_EXEC: begin
            state_d = S_WB;
            d_d     = w_alu_res;
            c_d     = w_alu_c;
            z_d     = (w_alu_res == '0);
            rdo_d   = rd_q;
         end
         S_MUL: begin
            prod_d = w_mul_next;
            if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
               state_d = S_WB;
               d_d     = w_mul_next[WIDTH-1:0];
               c_d     = |w_mul_next[2*WIDTH-1:WIDTH];
               z_d     = (w_mul_next[WIDTH-1:0] == '0);
               rdo_d   = rd_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The edge leaving WB is also an accept point, giving a 2-cycle issue rate.
      if (start && (state_q == S_IDLE || state_q == S_WB)) begin
         a_d     = A;
         b_d     = B;
         op_d    = op;
         rd_d    = rd_in;
         cnt_d   = '0;
         prod_d  = {{WIDTH{1'b0}}, B};
         state_d = (op == c_OP_MUL) ? S_MUL : S_EXEC;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         d_q     <= '0;
         rdo_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         d_q     <= d_d;
         rdo_q   <= rdo_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_WB);
   assign WE   = (state_q == S_WB) && (rdo_q != '0);
   assign D    = d_q;
   assign Rd   = rdo_q;
   assign Z    = z_q;
   assign C    = c_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_writeback.sv
// ============================================================================
//  Module   : tb_exec_writeback
//  Purpose  : Directed and randomized checks of exec_writeback against an
//             arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exec_writeback;

   logic        clk;
   logic        Reset;
   logic        start;
   logic [2:0]  op;
   logic [3:0]  rd_in;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] D;
   logic [3:0]  Rd;
   logic        WE;
   logic        Z;
   logic        C;

   int n_checks = 0;
   int n_errors = 0;

   exec_writeback dut (
      .clk   (clk),
      .Reset (Reset),
      .start (start),
      .op    (op),
      .rd_in (rd_in),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Rd    (Rd),
      .WE    (WE),
      .Z     (Z),
      .C     (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the operation definitions.
   task automatic ref_calc(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] d, output logic c);
      logic [31:0] full;
      int          sh;
      full = 32'd0;
      c    = 1'b0;
      case (o)
         3'd0: begin full = {16'd0, a} + {16'd0, b}; c = (full > 32'hFFFF); end
         3'd1: begin full = {16'd0, a - b};          c = (a < b);          end
         3'd2: full = {16'd0, a & b};
         3'd3: full = {16'd0, a | b};
         3'd4: full = {16'd0, a ^ b};
         3'd5: begin
            sh   = int'(b[3:0]);
            full = {16'd0, a} * (32'd1 << sh);
            c    = (sh != 0) && (((a >> (16 - sh)) & 16'd1) != 16'd0);
         end
         3'd6: begin full = {16'd0, a} * {16'd0, b}; c = (full >= 32'h10000); end
         default: full = {16'd0, b};
      endcase
      d = full[15:0];
   endtask

   task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] r);
      logic [15:0] ed;
      logic        ec;
      int          n;
      ref_calc(o, a, b, ed, ec);
      op = o; A = a; B = b; rd_in = r; start = 1'b1;
      tick();
      start = 1'b0;
      op = 3'($urandom); A = 16'($urandom); B = 16'($urandom); rd_in = 4'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("latency", n, (o == 3'd6) ? 16 : 1);
      chk("D", 32'(D), 32'(ed));
      chk("Rd", 32'(Rd), 32'(r));
      chk("WE", 32'(WE), (r != 4'd0) ? 32'd1 : 32'd0);
      chk("Z", 32'(Z), (ed == 16'd0) ? 32'd1 : 32'd0);
      chk("C", 32'(C), 32'(ec));
      chk("busy_wb", 32'(busy), 32'd1);
      tick();
      chk("done_after_wb", 32'(done), 32'd0);
      chk("WE_after_wb", 32'(WE), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("D_hold", 32'(D), 32'(ed));
   endtask

   initial begin
      logic [15:0] qd [$];
      logic        qc [$];
      logic [3:0]  qr [$];
      logic [15:0] ed;
      logic        ec;
      logic [2:0]  ro;
      int          ndone;

      Reset = 1'b0; start = 1'b0; op = '0; rd_in = '0; A = '0; B = '0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_WE", 32'(WE), 32'd0);
      chk("rst_D", 32'(D), 32'd0);
      chk("rst_Rd", 32'(Rd), 32'd0);
      chk("rst_ZC", {30'd0, Z, C}, 32'd0);
      Reset = 1'b1;
      tick();

      // Directed cases
      run_op(3'd0, 16'hFFFF, 16'h0001, 4'd3);
      run_op(3'd1, 16'h0005, 16'h0007, 4'd15);
      run_op(3'd5, 16'h8001, 16'h0001, 4'd2);
      run_op(3'd5, 16'h1234, 16'h0000, 4'd2);
      run_op(3'd6, 16'h0123, 16'h0045, 4'd7);
      run_op(3'd6, 16'h1000, 16'h0010, 4'd9);

      // Write to R0 with a start pulse while busy that must be ignored
      op = 3'd0; A = 16'd1; B = 16'd1; rd_in = 4'd0; start = 1'b1;
      tick();
      op = 3'd7; A = 16'hAAAA; B = 16'h5555; rd_in = 4'd5;
      tick();
      start = 1'b0;
      chk("r0_done", 32'(done), 32'd1);
      chk("r0_WE", 32'(WE), 32'd0);
      chk("r0_D", 32'(D), 32'h0002);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("busy_start_ignored", ndone, 0);

      // Reset during MUL iteration 8
      op = 3'd6; A = 16'h00FF; B = 16'h00FF; rd_in = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      #2 Reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_WE", 32'(WE), 32'd0);
      chk("midrst_D", 32'(D), 32'd0);
      #3 Reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("no_wb_after_reset", ndone, 0);
      run_op(3'd6, 16'h0102, 16'h0304, 4'd6);

      // Randomized single ops
      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom));
      end

      // Back-to-back with start held high: accepts every 2 cycles
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         do ro = 3'($urandom); while (ro == 3'd6);
         op = ro; A = 16'($urandom); B = 16'($urandom); rd_in = 4'($urandom);
         if (i % 2 == 0) begin
            ref_calc(ro, A, B, ed, ec);
            qd.push_back(ed); qc.push_back(ec); qr.push_back(rd_in);
         end
         tick();
         if (i % 2 == 1) begin
            ed = qd.pop_front(); ec = qc.pop_front();
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_D", 32'(D), 32'(ed));
            chk("b2b_C", 32'(C), 32'(ec));
            chk("b2b_WE", 32'(WE), (qr[0] != 4'd0) ? 32'd1 : 32'd0);
            chk("b2b_Rd", 32'(Rd), 32'(qr.pop_front()));
         end else begin
            chk("b2b_gap", {31'd0, done}, 32'd0);
         end
      end
      start = 1'b0;
      tick();
      tick();
      chk("b2b_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
